hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Load-use hazard detector and stall/flush sequencer for the 5-stage datapath. It covers the case
//  that ForwardA/ForwardB cannot resolve: a load result not ready in time. It freezes PC and IF/ID,
//  injects ID/EX bubbles for MEM_LAT cycles, and flushes IF/ID + ID/EX on a taken branch.
//  Sits beside the forwarding unit, consuming ID-stage source regs and the EX-stage load destination.
// PARAMETERS
//  MEM_LAT   1   stall cycles per load-use hazard (1..15)
//  CNT_W     32  width of the stall-cycle statistics counter
// PORTS
//  Clk             in   1      rising-edge clock
//  Rst             in   1      asynchronous, active-high reset
//  RS_ID           in   5      rs of instruction in ID
//  RT_ID           in   5      rt of instruction in ID
//  UsesRT_ID       in   1      ID instruction reads rt as a source (R-type, store, branch)
//  RD_EX           in   5      destination reg of instruction in EX
//  MemRead_EX      in   1      instruction in EX is a load
//  BranchTaken_EX  in   1      branch in EX resolved taken this cycle
//  PCWrite         out  1      1 = PC may update
//  IF_ID_Write     out  1      1 = IF/ID register may load
//  ID_EX_Bubble    out  1      1 = zero control fields into ID/EX
//  IF_ID_Flush     out  1      1 = clear IF/ID to NOP
//  Stalling        out  1      1 = FSM in STALL state (debug)
//  StallCycles     out  CNT_W  count of cycles PCWrite was 0, saturating at all-ones
// BEHAVIOUR
//  hazard = MemRead_EX && RD_EX!=0 && (RD_EX==RS_ID || (UsesRT_ID && RD_EX==RT_ID)) (combinational)
//  FSM states: IDLE, STALL. Down-counter cnt (4 bits).
//  Reset (async, any time incl. mid-stall): state=IDLE, cnt=0, StallCycles=0.
//   While Rst=1: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, Stalling=0.
//  IDLE, BranchTaken_EX=1: IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1. Hazard is ignored (the ID instr is squashed).
//   Stay in IDLE.
//  IDLE, hazard, no branch: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 in the same cycle (zero latency).
//   If MEM_LAT==1, stay IDLE. Otherwise go to STALL with cnt=MEM_LAT-1.
//  IDLE, neither: PCWrite=1, IF_ID_Write=1, Bubble=0, Flush=0.
//  STALL: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, Stalling=1. cnt decrements each cycle.
//   When cnt==1, go to IDLE next edge.
//   The hazard term is not re-evaluated in STALL: EX holds a bubble.
//  STALL with BranchTaken_EX=1: not reachable, because EX holds a bubble while stalled.
//   If it does occur, flush wins: Flush=1, Bubble=1, PCWrite=1, go to IDLE, cnt=0.
//  Total stall for one hazard = exactly MEM_LAT cycles of PCWrite=0.
//   Back-to-back load-use hazards each stall independently.
//  StallCycles increments on each rising edge where PCWrite==0. It holds at 2^CNT_W-1.
//  All comparisons are 5-bit unsigned equality. Register $0 never causes a hazard.
// STRUCTURE
//  Shared package/header: state encodings (ST_IDLE=1'b0, ST_STALL=1'b1), the REG_ZERO=5'd0 constant,
//   and the register-index width REG_W=5. This header is shared with the forwarding unit.
//  Sub-module: sat_counter (CNT_W, inc, Clk, Rst) implements StallCycles. Everything else stays inline.
// TESTING
//  1. lw $2 in EX, add $3,$2,$4 in ID, MEM_LAT=1 -> one cycle PCWrite=0/Bubble=1, then PCWrite=1.
//     StallCycles=1.
//  2. Same with MEM_LAT=3 -> PCWrite=0 for exactly 3 cycles; Stalling=1 for cycles 2-3.
//     StallCycles=3.
//  3. lw $0 in EX, ID reads $0 -> no stall. lw $5, ID uses rt=$5 with UsesRT_ID=0 -> no stall.
//  4. Hazard and BranchTaken_EX in the same cycle -> Flush=1, Bubble=1, PCWrite=1, no stall afterwards.
//  5. Assert Rst during the 2nd cycle of a MEM_LAT=3 stall -> outputs immediately PCWrite=1,
//     Stalling=0, StallCycles=0. After release, state is IDLE.
//  6. CNT_W=4, force 20 stall cycles -> StallCycles saturates at 15.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings for the hazard stall unit and the forwarding unit:
// FSM states, register-index width and the hard-wired zero register.
package hazard_stall_unit_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Load-use test: the EX load writes a register the ID instruction reads; $0 never counts.
  function automatic logic load_use(input logic             mem_read,
                                    input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rt,
                                    input logic             uses_rt);
    return mem_read && (rd != REG_ZERO) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating event counter: counts cycles with inc high and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detector and stall/flush sequencer: freezes PC and IF/ID,
// bubbles ID/EX for MEM_LAT cycles per hazard, and flushes on a taken branch.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [REG_W-1:0] RS_ID,
  input  logic [REG_W-1:0] RT_ID,
  input  logic             UsesRT_ID,
  input  logic [REG_W-1:0] RD_EX,
  input  logic             MemRead_EX,
  input  logic             BranchTaken_EX,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             Stalling,
  output logic [CNT_W-1:0] StallCycles
);

  // The first stall cycle is spent in IDLE, so STALL covers the remaining MEM_LAT-1.
  localparam logic [3:0] STALL_INIT = 4'(MEM_LAT - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       hazard;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    hazard       = load_use(MemRead_EX, RD_EX, RS_ID, RT_ID, UsesRT_ID);
    state_next   = state;
    cnt_next     = cnt;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    Stalling     = 1'b0;

    case (state)
      ST_IDLE: begin
        // A taken branch squashes the ID instruction, so its hazard is moot.
        if (BranchTaken_EX) begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
        end else if (hazard) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          if (MEM_LAT > 1) begin
            state_next = ST_STALL;
            cnt_next   = STALL_INIT;
          end
        end
      end
      ST_STALL: begin
        if (BranchTaken_EX) begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
          state_next   = ST_IDLE;
          cnt_next     = 4'd0;
        end else begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          Stalling     = 1'b1;
          cnt_next     = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase

    // Reset forces a free-running pipeline regardless of the hazard inputs.
    if (Rst) begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Bubble = 1'b0;
      IF_ID_Flush  = 1'b0;
      Stalling     = 1'b0;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .Clk  (Clk),
    .Rst  (Rst),
    .inc  (~PCWrite),
    .count(StallCycles)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: instance A (MEM_LAT=1, 32-bit count) runs a vector table,
// instance B (MEM_LAT=3, 4-bit count) runs multi-cycle stall/reset/saturation sequences.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_uses_rt, a_mem_read, a_branch;
  logic [4:0]  a_rs, a_rt, a_rd;
  logic        a_pc_write, a_if_id_write, a_bubble, a_flush, a_stalling;
  logic [31:0] a_stall_cycles;

  logic        b_rst, b_uses_rt, b_mem_read, b_branch;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic        b_pc_write, b_if_id_write, b_bubble, b_flush, b_stalling;
  logic [3:0]  b_stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] rd;
    logic       mem_read;
    logic       branch;
    logic       pc;
    logic       ifid;
    logic       bubble;
    logic       flush;
  } vec_t;

  vec_t vecs[10];

  hazard_stall_unit #(.MEM_LAT(1), .CNT_W(32)) dut_a (
    .Clk(clk), .Rst(a_rst), .RS_ID(a_rs), .RT_ID(a_rt), .UsesRT_ID(a_uses_rt),
    .RD_EX(a_rd), .MemRead_EX(a_mem_read), .BranchTaken_EX(a_branch),
    .PCWrite(a_pc_write), .IF_ID_Write(a_if_id_write), .ID_EX_Bubble(a_bubble),
    .IF_ID_Flush(a_flush), .Stalling(a_stalling), .StallCycles(a_stall_cycles)
  );

  hazard_stall_unit #(.MEM_LAT(3), .CNT_W(4)) dut_b (
    .Clk(clk), .Rst(b_rst), .RS_ID(b_rs), .RT_ID(b_rt), .UsesRT_ID(b_uses_rt),
    .RD_EX(b_rd), .MemRead_EX(b_mem_read), .BranchTaken_EX(b_branch),
    .PCWrite(b_pc_write), .IF_ID_Write(b_if_id_write), .ID_EX_Bubble(b_bubble),
    .IF_ID_Flush(b_flush), .Stalling(b_stalling), .StallCycles(b_stall_cycles)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a_rs       = v.rs;
    a_rt       = v.rt;
    a_uses_rt  = v.uses_rt;
    a_rd       = v.rd;
    a_mem_read = v.mem_read;
    a_branch   = v.branch;
  endtask

  task automatic driveB(input logic [4:0] rs, input logic [4:0] rd,
                        input logic mem_read, input logic branch);
    b_rs       = rs;
    b_rt       = 5'd0;
    b_uses_rt  = 1'b0;
    b_rd       = rd;
    b_mem_read = mem_read;
    b_branch   = branch;
  endtask

  task automatic checkB(input string tag, input logic pc, input logic stalling,
                        input logic bubble, input logic flush);
    checkOutput({tag, "_pc"},       32'(b_pc_write), 32'(pc));
    checkOutput({tag, "_ifid"},     32'(b_if_id_write), 32'(pc));
    checkOutput({tag, "_stalling"}, 32'(b_stalling), 32'(stalling));
    checkOutput({tag, "_bubble"},   32'(b_bubble), 32'(bubble));
    checkOutput({tag, "_flush"},    32'(b_flush), 32'(flush));
  endtask

  initial begin
    int exp_a_cnt;
    int exp_b_cnt;

    //            rs     rt     ursr  rd     mr    br    pc    ifid  bub   flush
    vecs[0] = '{5'd3,  5'd4,  1'b1, 5'd2,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{5'd2,  5'd4,  1'b1, 5'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{5'd7,  5'd2,  1'b1, 5'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{5'd7,  5'd5,  1'b0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{5'd9,  5'd1,  1'b1, 5'd9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{5'd2,  5'd4,  1'b1, 5'd2,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{5'd3,  5'd4,  1'b1, 5'd2,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{5'd31, 5'd0,  1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{5'd31, 5'd0,  1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset with a live hazard on A: outputs must still show a free-running pipeline.
    a_rst = 1'b1;
    b_rst = 1'b1;
    applyStimulus(vecs[1]);
    driveB(5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("rst_a_pc",     32'(a_pc_write), 32'd1);
    checkOutput("rst_a_ifid",   32'(a_if_id_write), 32'd1);
    checkOutput("rst_a_bubble", 32'(a_bubble), 32'd0);
    checkOutput("rst_a_flush",  32'(a_flush), 32'd0);
    checkOutput("rst_a_stall",  32'(a_stalling), 32'd0);
    checkOutput("rst_a_count",  a_stall_cycles, 32'd0);
    checkOutput("rst_b_count",  32'(b_stall_cycles), 32'd0);

    @(negedge clk);
    applyStimulus(vecs[0]);
    a_mem_read = 1'b0;
    a_rst = 1'b0;
    b_rst = 1'b0;

    exp_a_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_pc", i),       32'(a_pc_write), 32'(vecs[i].pc));
      checkOutput($sformatf("vec%0d_ifid", i),     32'(a_if_id_write), 32'(vecs[i].ifid));
      checkOutput($sformatf("vec%0d_bubble", i),   32'(a_bubble), 32'(vecs[i].bubble));
      checkOutput($sformatf("vec%0d_flush", i),    32'(a_flush), 32'(vecs[i].flush));
      checkOutput($sformatf("vec%0d_stalling", i), 32'(a_stalling), 32'd0);
      checkOutput($sformatf("vec%0d_count", i),    a_stall_cycles, 32'(exp_a_cnt));
      if (!vecs[i].pc) exp_a_cnt++;
    end
    @(negedge clk);
    applyStimulus(vecs[5]);
    #1;
    checkOutput("a_final_count", a_stall_cycles, 32'(exp_a_cnt));
    checkOutput("a_final_pc",    32'(a_pc_write), 32'd1);

    // MEM_LAT=3 load-use: exactly three cycles of PCWrite=0, Stalling on cycles 2-3.
    @(negedge clk);
    driveB(5'd2, 5'd2, 1'b1, 1'b0);
    #1;
    checkB("lat3_c1", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    driveB(5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checkB("lat3_c2", 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    checkB("lat3_c3", 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    checkB("lat3_c4", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lat3_count", 32'(b_stall_cycles), 32'd3);

    // Hazard coinciding with a taken branch: flush only, no stall afterwards.
    @(negedge clk);
    driveB(5'd2, 5'd2, 1'b1, 1'b1);
    #1;
    checkB("br_c1", 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    driveB(5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checkB("br_c2", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("br_count", 32'(b_stall_cycles), 32'd3);

    // Reset asserted in the middle of a stall.
    @(negedge clk);
    driveB(5'd2, 5'd2, 1'b1, 1'b0);
    #1;
    checkB("mid_c1", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    driveB(5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checkB("mid_c2", 1'b0, 1'b1, 1'b1, 1'b0);
    b_rst = 1'b1;
    #1;
    checkB("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst_count", 32'(b_stall_cycles), 32'd0);
    @(negedge clk);
    b_rst = 1'b0;
    #1;
    checkB("mid_rel1", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkB("mid_rel2", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rel_count", 32'(b_stall_cycles), 32'd0);

    // Seven back-to-back hazards = 21 stall cycles into a 4-bit counter.
    exp_b_cnt = 0;
    for (int h = 0; h < 7; h++) begin
      @(negedge clk);
      driveB(5'd6, 5'd6, 1'b1, 1'b0);
      @(negedge clk);
      driveB(5'd0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1;
      exp_b_cnt = (exp_b_cnt + 3 > 15) ? 15 : exp_b_cnt + 3;
      checkOutput($sformatf("sat_h%0d_count", h), 32'(b_stall_cycles), 32'(exp_b_cnt));
      checkOutput($sformatf("sat_h%0d_pc", h),    32'(b_pc_write), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
